// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and constants for the FT245 synchronous FIFO transmit path
package ft_pkg;

    localparam int FT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SEND,
        ST_RELEASE,
        ST_SIWU
    } ft_tx_state_t;

endpackage

// File: rtl/ft_sync_tx_if.sv
// rtl/ft_sync_tx_if.sv - byte source handshake and flush request into ft_sync_tx
interface ft_sync_tx_if;
    import ft_pkg::*;

    logic [FT_DATA_W-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 flush;

    modport master (
        output din,
        output din_valid,
        output flush,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        input  flush,
        output din_ready
    );
endinterface

// File: rtl/ft_tx_fifo.sv
// rtl/ft_tx_fifo.sv - single-clock circular byte buffer with combinational head
// next_head is the byte that becomes head after a pop on this edge, bypassing a same-edge push.
module ft_tx_fifo
    import ft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 push,
    input  logic [FT_DATA_W-1:0] wr_data,
    input  logic                 pop,
    output logic [FT_DATA_W-1:0] head,
    output logic [FT_DATA_W-1:0] next_head,
    output logic [LVL_W-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [FT_DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_ptr_nx;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign head      = mem[rd_ptr];
    assign next_head = (count > LVL_W'(1)) ? mem[rd_ptr_nx] : wr_data;
endmodule

// File: rtl/ft_sync_tx.sv
// rtl/ft_sync_tx.sv - FT232H/FT2232H sync 245-FIFO transmitter: buffer, bus FSM, write strobe
// Optional send-immediate (flush flag, SIWU state, siwub pulse) enabled by FT_TX_SIWU_EN.
module ft_sync_tx
    import ft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_,
    ft_sync_tx_if.slave          src,
    input  logic                 bus_gnt,
    input  logic                 txe_,
    output logic [FT_DATA_W-1:0] ad_out,
    output logic                 ad_oe,
    output logic                 wr_,
    output logic                 siwub,
    output logic [LVL_W-1:0]     level
);
    ft_tx_state_t         state_q;
    ft_tx_state_t         state_d;
    logic [FT_DATA_W-1:0] ad_out_d;
    logic [FT_DATA_W-1:0] head;
    logic [FT_DATA_W-1:0] next_head;
    logic                 push;
    logic                 pop;
    logic                 ad_oe_d;
    logic                 wr_d;

    assign src.din_ready = (level < LVL_W'(DEPTH));
    assign push          = src.din_valid & src.din_ready;

    ft_tx_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push      (push),
        .wr_data   (src.din),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .count     (level)
    );

`ifdef FT_TX_SIWU_EN
    logic flush_q;
    logic siwub_d;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= src.flush | (flush_q & (state_q != ST_SIWU));
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        ad_out_d = ad_out;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_gnt && !txe_ && level != '0) begin
                    state_d  = ST_DRIVE;
                    ad_out_d = head;
                end
`ifdef FT_TX_SIWU_EN
                else if (flush_q && level == '0 && bus_gnt) begin
                    state_d = ST_SIWU;
                end
`endif
            end
            ST_DRIVE: begin
                ad_out_d = head;
                state_d  = (bus_gnt && !txe_) ? ST_SEND : ST_RELEASE;
            end
            ST_SEND: begin
                // wr_ is low for the whole state, so any edge with txe_ low moves a byte
                pop = !txe_;
                if (!txe_ && bus_gnt && (level > LVL_W'(1) || push)) begin
                    ad_out_d = next_head;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_SIWU:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign wr_d    = (state_d != ST_SEND);
    assign ad_oe_d = (state_d == ST_DRIVE) || (state_d == ST_SEND) || (state_d == ST_RELEASE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            wr_     <= 1'b1;
        end else begin
            state_q <= state_d;
            ad_out  <= ad_out_d;
            ad_oe   <= ad_oe_d;
            wr_     <= wr_d;
        end
    end

`ifdef FT_TX_SIWU_EN
    assign siwub_d = (state_d != ST_SIWU);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            siwub <= 1'b1;
        end else begin
            siwub <= siwub_d;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = src.flush;
    assign siwub        = 1'b1;
`endif
endmodule

// File: tb/tb_ft_sync_tx.sv
// tb/tb_ft_sync_tx.sv - scoreboard bench for ft_sync_tx with directed byte bursts
module tb_ft_sync_tx;
    import ft_pkg::*;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic             bus_gnt = 1'b1;
    logic             txe_ = 1'b0;
    logic [7:0]       ad_out;
    logic             ad_oe;
    logic             wr_;
    logic             siwub;
    logic [LVL_W-1:0] level;

    ft_sync_tx_if ifc ();

    ft_sync_tx #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .src     (ifc),
        .bus_gnt (bus_gnt),
        .txe_    (txe_),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .wr_     (wr_),
        .siwub   (siwub),
        .level   (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_low_cnt = 0;
    int siwub_low_cnt = 0;
    int write_cnt = 0;
    int accepted = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a write happens on the coming edge when wr_ and txe_ are both low
    always @(negedge clk) begin
        if (rst_) begin
            if (!wr_) wr_low_cnt++;
            if (!siwub) siwub_low_cnt++;
            if (!wr_ && !txe_) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, ad_out}, 32'hFFFF_FFFF);
                end else begin
                    check("write_data", {24'd0, ad_out}, {24'd0, exp_q.pop_front()});
                    check("write_oe", {31'd0, ad_oe}, 32'd1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        ifc.din = b;
        ifc.din_valid = 1'b1;
        if (ifc.din_ready) begin
            exp_q.push_back(b);
            accepted++;
        end
        tick();
        ifc.din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (level == '0 && ad_oe == 1'b0 && wr_ == 1'b1) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'd0, done}, 32'd1);
        check({name, "_queue"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] t2_bytes[5];
        int exp_siwu;
        t2_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
`ifdef FT_TX_SIWU_EN
        exp_siwu = 1;
`else
        exp_siwu = 0;
`endif
        ifc.din = 8'h00;
        ifc.din_valid = 1'b0;
        ifc.flush = 1'b0;
        #12;
        check("rst_wr", {31'd0, wr_}, 32'd1);
        check("rst_siwub", {31'd0, siwub}, 32'd1);
        check("rst_oe", {31'd0, ad_oe}, 32'd0);
        check("rst_ad_out", {24'd0, ad_out}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_din_ready", {31'd0, ifc.din_ready}, 32'd1);
        rst_ = 1'b1;
        tick();

        // T1: three bytes, wr_ low for exactly three cycles
        wr_low_cnt = 0;
        drive_byte(8'h11);
        check("t1_idle", {31'd0, ad_oe}, 32'd0);
        drive_byte(8'h22);
        check("t1_drive_oe", {31'd0, ad_oe}, 32'd1);
        check("t1_drive_wr", {31'd0, wr_}, 32'd1);
        drive_byte(8'h33);
        check("t1_send_wr", {31'd0, wr_}, 32'd0);
        check("t1_send_data", {24'd0, ad_out}, 32'h11);
        repeat (3) tick();
        check("t1_release_wr", {31'd0, wr_}, 32'd1);
        check("t1_release_oe", {31'd0, ad_oe}, 32'd1);
        check("t1_release_hold", {24'd0, ad_out}, 32'h33);
        check("t1_level", {27'd0, level}, 32'd0);
        tick();
        check("t1_idle_oe", {31'd0, ad_oe}, 32'd0);
        check("t1_wr_low_cycles", wr_low_cnt, 32'd3);

        // T2: five bytes, txe_ high for two cycles after the second write
        write_cnt = 0;
        txe_ = 1'b1;
        foreach (t2_bytes[i]) drive_byte(t2_bytes[i]);
        txe_ = 1'b0;
        repeat (4) tick();
        check("t2_level_mid", {27'd0, level}, 32'd3);
        txe_ = 1'b1;
        tick();
        check("t2_release_wr", {31'd0, wr_}, 32'd1);
        check("t2_release_oe", {31'd0, ad_oe}, 32'd1);
        tick();
        txe_ = 1'b0;
        wait_idle("t2_drain");
        check("t2_writes", write_cnt, 32'd5);

        // T3: fill past DEPTH with txe_ high
        txe_ = 1'b1;
        accepted = 0;
        for (int i = 0; i < DEPTH + 4; i++) drive_byte(8'h40 + 8'(i));
        check("t3_accepted", accepted, DEPTH);
        check("t3_level_full", {27'd0, level}, DEPTH);
        check("t3_din_ready", {31'd0, ifc.din_ready}, 32'd0);
        write_cnt = 0;
        txe_ = 1'b0;
        wait_idle("t3_drain");
        check("t3_writes", write_cnt, DEPTH);

        // T4: no bus grant keeps the pads released
        bus_gnt = 1'b0;
        drive_byte(8'h5A);
        drive_byte(8'h6B);
        repeat (4) tick();
        check("t4_oe_nognt", {31'd0, ad_oe}, 32'd0);
        check("t4_wr_nognt", {31'd0, wr_}, 32'd1);
        check("t4_level", {27'd0, level}, 32'd2);
        bus_gnt = 1'b1;
        tick();
        check("t4_drive_oe", {31'd0, ad_oe}, 32'd1);
        check("t4_drive_wr", {31'd0, wr_}, 32'd1);
        tick();
        check("t4_send_wr", {31'd0, wr_}, 32'd0);
        wait_idle("t4_drain");

        // T5: flush after a single byte
        siwub_low_cnt = 0;
        ifc.flush = 1'b1;
        drive_byte(8'hA5);
        ifc.flush = 1'b0;
        repeat (5) tick();
        check("t5_siwub_pulse", {31'd0, siwub}, exp_siwu ? 32'd0 : 32'd1);
        tick();
        check("t5_siwub_end", {31'd0, siwub}, 32'd1);
        repeat (4) tick();
        check("t5_siwub_cycles", siwub_low_cnt, exp_siwu);
        check("t5_queue", exp_q.size(), 32'd0);

        // T6: reset during SEND
        drive_byte(8'h71);
        drive_byte(8'h72);
        drive_byte(8'h73);
        drive_byte(8'h74);
        check("t6_in_send", {31'd0, wr_}, 32'd0);
        rst_ = 1'b0;
        #1;
        check("t6_rst_wr", {31'd0, wr_}, 32'd1);
        check("t6_rst_oe", {31'd0, ad_oe}, 32'd0);
        check("t6_rst_siwub", {31'd0, siwub}, 32'd1);
        check("t6_rst_level", {27'd0, level}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_ = 1'b1;
        write_cnt = 0;
        repeat (10) tick();
        check("t6_no_writes", write_cnt, 32'd0);
        check("t6_level_after", {27'd0, level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
